// File: rtl/booth_mult_ctrl_pkg.sv
// booth_mult_ctrl_pkg: shared multdiv types and width constants.
package booth_mult_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MULT_STEPS = 32;
  localparam int OP_W = 32;
  localparam int PROD_W = 65;
endpackage

// File: rtl/booth_mult_ctrl_if.sv
// booth_mult_ctrl_if: start/operand/result bundle between ALU and Booth multiplier.
interface booth_mult_ctrl_if;
  import booth_mult_ctrl_pkg::*;
  logic ctrl_MULT;
  logic [OP_W-1:0] data_operandA;
  logic [OP_W-1:0] data_operandB;
  logic [OP_W-1:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  logic busy;
  modport master (output ctrl_MULT, data_operandA, data_operandB,
                  input data_result, data_exception, data_resultRDY, busy);
  modport slave (input ctrl_MULT, data_operandA, data_operandB,
                 output data_result, data_exception, data_resultRDY, busy);
endinterface

// File: rtl/booth_mult_ctrl_prod_reg65_sr.sv
// prod_reg65_sr: 65-bit product register with sync active-low clear and write enable.
module prod_reg65_sr
  import booth_mult_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [PROD_W-1:0] i_d,
  output logic [PROD_W-1:0] o_q
);
  logic [PROD_W-1:0] r_q;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_q <= '0;
    else if (i_en) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: sequential 32x32 signed radix-2 Booth multiplier with overflow flag.
module booth_mult_ctrl
  import booth_mult_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  booth_mult_ctrl_if.slave  bus
);
  state_t r_state;
  logic [OP_W-1:0] r_a;
  logic [4:0] r_cnt;
  logic [OP_W-1:0] r_result;
  logic r_exc;
  logic r_rdy;
  logic r_busy;
  logic [PROD_W-1:0] w_p;
  logic [PROD_W-1:0] w_p_step;
  logic [PROD_W-1:0] w_p_d;
  logic [OP_W:0] w_up;
  logic [OP_W:0] w_a;
  logic [OP_W:0] w_sum;
  logic w_start;
  logic w_en;
  assign w_start = (r_state == IDLE) && bus.ctrl_MULT;
  assign w_en = w_start || (r_state == RUN);
  assign w_up = {w_p[PROD_W-1], w_p[PROD_W-1:OP_W+1]};
  assign w_a = {r_a[OP_W-1], r_a};
  // 33-bit sum keeps A = 0x80000000 from wrapping the accumulator
  assign w_sum = (w_p[1:0] == 2'b01) ? w_up + w_a :
                 (w_p[1:0] == 2'b10) ? w_up - w_a : w_up;
  assign w_p_step = {w_sum, w_p[OP_W:1]};
  assign w_p_d = w_start ? {{OP_W{1'b0}}, bus.data_operandB, 1'b0} : w_p_step;
  prod_reg65_sr u_prod (
    .i_clk(clock),
    .i_rst_n(reset),
    .i_en(w_en),
    .i_d(w_p_d),
    .o_q(w_p)
  );
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_a <= '0;
      r_cnt <= '0;
      r_result <= '0;
      r_exc <= 1'b0;
      r_rdy <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b0;
          if (bus.ctrl_MULT) begin
            r_a <= bus.data_operandA;
            r_cnt <= '0;
            r_busy <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(MULT_STEPS - 1)) begin
            r_result <= w_p_step[OP_W:1];
            r_exc <= w_p_step[PROD_W-1:OP_W+1] != {OP_W{w_p_step[OP_W]}};
            r_rdy <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_rdy <= 1'b0;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.data_result = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_booth_mult_ctrl.sv
// tb_booth_mult_ctrl: randomized and directed checks against a cycle-count/arithmetic model.
module tb_booth_mult_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic armed = 1'b0;
  int checks = 0;
  int errors = 0;
  booth_mult_ctrl_if bus();
  booth_mult_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int m_t = 0;
  longint m_prod = 0;
  logic [31:0] m_res = '0;
  logic m_exc = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: m_t counts cycles since the accepted start, 0 meaning idle
  always @(posedge clock) begin
    if (!reset) begin
      m_t = 0;
      m_res = '0;
      m_exc = 1'b0;
    end else if (m_t == 0) begin
      if (bus.ctrl_MULT) begin
        longint pa, pb;
        pa = $signed(bus.data_operandA);
        pb = $signed(bus.data_operandB);
        m_prod = pa * pb;
        m_t = 1;
      end
    end else if (m_t == 33) begin
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == 33) begin
        m_res = m_prod[31:0];
        m_exc = m_prod != longint'($signed(m_prod[31:0]));
      end
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("busy", 64'(bus.busy), 64'(m_t != 0));
      chk("rdy", 64'(bus.data_resultRDY), 64'(m_t == 33));
      chk("result", 64'(bus.data_result), 64'(m_res));
      chk("exception", 64'(bus.data_exception), 64'(m_exc));
    end
  end
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                        input int rst_at, output int lat, output int pulses);
    lat = 0;
    pulses = 0;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i;
      end
      bus.ctrl_MULT = (i == pulse_at);
      if (i == pulse_at) begin
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
      end
      reset = (i != rst_at);
    end
  endtask
  task automatic do_test(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, input int rst_at, input logic [31:0] exp_res,
                         input logic exp_exc, input int exp_pulses);
    int lat, pulses;
    run_op(a, b, pulse_at, rst_at, lat, pulses);
    chk({name, "_pulses"}, 64'(pulses), 64'(exp_pulses));
    chk({name, "_latency"}, 64'(lat), exp_pulses != 0 ? 64'd33 : 64'd0);
    chk({name, "_result"}, 64'(bus.data_result), 64'(exp_res));
    chk({name, "_exception"}, 64'(bus.data_exception), 64'(exp_exc));
  endtask
  initial begin
    reset = 1'b0;
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = 32'd1;
    bus.data_operandB = 32'd1;
    repeat (3) @(posedge clock);
    #1;
    armed = 1'b1;
    @(negedge clock);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_rdy", 64'(bus.data_resultRDY), 64'd0);
    chk("reset_result", 64'(bus.data_result), 64'd0);
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    do_test("3x5", 32'd3, 32'd5, 0, 0, 32'h0000000F, 1'b0, 1);
    do_test("m7x6", -32'sd7, 32'd6, 0, 0, 32'hFFFFFFD6, 1'b0, 1);
    do_test("min_sq", 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1'b1, 1);
    do_test("max_x2", 32'h7FFFFFFF, 32'd2, 0, 0, 32'hFFFFFFFE, 1'b1, 1);
    do_test("2p16_sq", 32'h00010000, 32'h00010000, 0, 0, 32'h00000000, 1'b1, 1);
    do_test("ignored_start", 32'd3, 32'd5, 10, 0, 32'h0000000F, 1'b0, 1);
    do_test("reset_mid", 32'd3, 32'd5, 0, 12, 32'h00000000, 1'b0, 0);
    do_test("m1_sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000001, 1'b0, 1);
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, b;
      int lat, pulses, pa;
      a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      if ($urandom_range(0, 1) == 0) a = $signed(a) >>> $urandom_range(0, 30);
      if ($urandom_range(0, 1) == 0) b = $signed(b) >>> $urandom_range(0, 30);
      pa = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 33) : 0;
      run_op(a, b, pa, 0, lat, pulses);
      chk("rand_pulses", 64'(pulses), 64'd1);
      chk("rand_latency", 64'(lat), 64'd33);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/booth_mult_ctrl.md
# booth_mult_ctrl

Sequential 32x32 signed radix-2 Booth multiplier for the multdiv unit. It owns the 65-bit product register {upper accumulator, multiplier word, Booth guard bit} and its enable. Each cycle it computes the register's next value. After 32 add/subtract-and-shift steps it presents the low 32-bit product and an overflow exception to the ALU writeback path.

## Interface
- No parameters; widths fixed: operand 32, product register 65, step counter 5.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; all state cleared when low at a rising edge.
- ctrl_MULT  in  1  start pulse; sampled only in IDLE.
- data_operandA  in  32  multiplicand, signed; sampled with accepted start.
- data_operandB  in  32  multiplier, signed; sampled with accepted start.
- data_result  out  32  product bits [31:0]; held until next accepted start.
- data_exception  out  1  product does not fit in 32 signed bits; held with data_result.
- data_resultRDY  out  1  one-cycle pulse marking result/exception valid.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with ctrl_MULT=1: latch A into the 32-bit multiplicand register. Load P = {32'b0, B, 1'b0}, clear the counter, go to RUN.
- RUN, each edge:
  - P[1:0]=01: upper' = P[64:33] + A.
  - P[1:0]=10: upper' = P[64:33] - A.
  - P[1:0]=00 or 11: upper unchanged.
  - Form the 33-bit sign-extended sum S from upper'.
  - New P = {S[32], S[31:0], P[32:1]}, an arithmetic shift right by 1 using the 33-bit sign.
  - Increment the counter.
- Counter reaches 31 on the step being executed: that step completes, then go to DONE.
- DONE, one cycle:
  - data_resultRDY=1.
  - data_result = P[32:1].
  - data_exception = 1 unless P[64:33] all equal P[32].
  - Next edge goes to IDLE.
- data_result and data_exception are registered on entry to DONE and are stable from then until the next accepted start.
- ctrl_MULT in RUN or DONE is ignored; no queueing.
- Operands may change freely after the start cycle.
- Reset values: state=IDLE, P=0, multiplicand=0, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.

## Timing
- Start sampled at edge k. RUN occupies edges k+1..k+32. data_resultRDY is high for exactly the cycle after edge k+32, i.e. 33 cycles after start.
- A new start is accepted at the earliest 2 edges after the DONE entry edge, once back in IDLE.
- Back-to-back operation therefore has a throughput of one multiply per 34 cycles.
- reset low mid-RUN or in DONE: next edge forces IDLE, all reset values apply, and no data_resultRDY is produced.
- reset low with ctrl_MULT=1: reset wins; start is not accepted.
- Extreme operand A = 0x80000000: must be correct via the 33-bit sum; no wrap in the upper accumulator.

## Structure
- Shared multdiv package:
  - state enum (IDLE/RUN/DONE);
  - MULT_STEPS=32;
  - width constants 32/65.
- One sub-module: prod_reg65_sr. It is a 65-bit register with synchronous active-low clear and write enable, and holds P.
- Next-state datapath (33-bit add/sub, shift) and FSM stay in booth_mult_ctrl.

## Test plan
- A=3, B=5, start -> data_resultRDY at cycle 33, data_result=0x0000000F, data_exception=0, busy low the cycle after.
- A=-7, B=6 -> data_result=0xFFFFFFD6, data_exception=0.
- A=0x80000000, B=0x80000000 -> data_result=0x00000000, data_exception=1 (true product 2^62).
- A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1. A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1.
- A=3, B=5; pulse ctrl_MULT with A=9, B=9 at cycle 10 -> ignored, result 0x0000000F at cycle 33, exactly one data_resultRDY pulse.
- A=3, B=5; start, reset low for one cycle at cycle 12 -> no data_resultRDY, outputs 0. A fresh start A=-1, B=-1 then yields data_result=1, data_exception=0, 33 cycles after that start.
